// File: rtl/ysyx_22040365_regfile_sb.sv
// Two-read / one-write integer register file with x0 hardwired to zero and a per-register busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module ysyx_22040365_regfile_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic                  ren_rs1,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy1,
    input  logic                  ren_rs2,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  busy2,
    output logic                  busy_any
);

    localparam int NR_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf_q [NR_REGS];
    logic [DATA_WIDTH-1:0] rf_d [NR_REGS];
    logic [NR_REGS-1:0]    busy_q;
    logic [NR_REGS-1:0]    busy_d;
    logic                  wr_hit;

    assign wr_hit = wen && (waddr != '0);

    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        if (wr_hit) begin
            rf_d[waddr] = wdata;
        end
        // Issue beats a same-cycle writeback: the newer instruction owns rd.
        for (int unsigned i = 1; i < NR_REGS; i++) begin
            if (iss_valid && (iss_rd == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wen && (waddr == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
        rf_d[0]   = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NR_REGS; i++) begin
                rf_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NR_REGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
            busy_q <= busy_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;

    assign fwd1 = wr_hit && (waddr == raddr1);
    assign fwd2 = wr_hit && (waddr == raddr2);

    always_comb begin
        rdata1 = '0;
        busy1  = 1'b0;
        if (ren_rs1) begin
            rdata1 = fwd1 ? wdata : rf_q[raddr1];
            busy1  = busy_q[raddr1] && !fwd1;
        end
    end

    always_comb begin
        rdata2 = '0;
        busy2  = 1'b0;
        if (ren_rs2) begin
            rdata2 = fwd2 ? wdata : rf_q[raddr2];
            busy2  = busy_q[raddr2] && !fwd2;
        end
    end
`else
    always_comb begin
        rdata1 = '0;
        busy1  = 1'b0;
        if (ren_rs1) begin
            rdata1 = rf_q[raddr1];
            busy1  = busy_q[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        busy2  = 1'b0;
        if (ren_rs2) begin
            rdata2 = rf_q[raddr2];
            busy2  = busy_q[raddr2];
        end
    end
`endif

    assign busy_any = |busy_q;

endmodule

// File: tb/tb_ysyx_22040365_regfile_sb.sv
// Directed plus seeded-random checks of ysyx_22040365_regfile_sb against hand-computed values and a small model.
module tb_ysyx_22040365_regfile_sb;

    logic        clk;
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        ren_rs1;
    logic [4:0]  raddr1;
    logic [63:0] rdata1;
    logic        busy1;
    logic        ren_rs2;
    logic [4:0]  raddr2;
    logic [63:0] rdata2;
    logic        busy2;
    logic        busy_any;

    int unsigned n_cmp;
    int unsigned n_err;

    logic [63:0] m_rf [32];
    logic [31:0] m_busy;

    ysyx_22040365_regfile_sb #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wen      (wen),
        .waddr    (waddr),
        .wdata    (wdata),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .ren_rs1  (ren_rs1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .busy1    (busy1),
        .ren_rs2  (ren_rs2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .busy2    (busy2),
        .busy_any (busy_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen       = 1'b0;
        waddr     = '0;
        wdata     = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
    endtask

    function automatic logic [63:0] exp_rd(input logic ren, input logic [4:0] ra);
        logic [63:0] v;
        v = '0;
        if (ren) begin
            v = m_rf[ra];
`ifdef REGFILE_BYPASS_EN
            if (wen && waddr != 0 && waddr == ra) v = wdata;
`endif
        end
        return v;
    endfunction

    function automatic logic exp_busy(input logic ren, input logic [4:0] ra);
        logic b;
        b = ren && m_busy[ra];
`ifdef REGFILE_BYPASS_EN
        if (wen && waddr != 0 && waddr == ra) b = 1'b0;
`endif
        return b;
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle();
        rst = 1'b1;
        ren_rs1 = 1'b1;
        raddr1 = 5'd5;
        ren_rs2 = 1'b1;
        raddr2 = 5'd6;
        #1;
        chk("rst_rdata1", rdata1, 64'h0);
        chk("rst_busy_any", {63'h0, busy_any}, 64'h0);

        // writes and issues ignored while reset is held
        wen = 1'b1; waddr = 5'd5; wdata = 64'hAA;
        iss_valid = 1'b1; iss_rd = 5'd6;
        tick();
        chk("rst_hold_rdata1", rdata1, 64'h0);
        chk("rst_hold_busy2", {63'h0, busy2}, 64'h0);
        chk("rst_hold_busy_any", {63'h0, busy_any}, 64'h0);
        idle();
        rst = 1'b0;
        tick();

        // Test 1: async reset mid-run
        wen = 1'b1; waddr = 5'd5; wdata = 64'hA5;
        iss_valid = 1'b1; iss_rd = 5'd6;
        tick();
        idle();
        #1;
        chk("t1_pre_rdata1", rdata1, 64'hA5);
        chk("t1_pre_busy2", {63'h0, busy2}, 64'h1);
        chk("t1_pre_busy_any", {63'h0, busy_any}, 64'h1);
        #1 rst = 1'b1;
        #1;
        chk("t1_rdata1", rdata1, 64'h0);
        chk("t1_busy2", {63'h0, busy2}, 64'h0);
        chk("t1_busy_any", {63'h0, busy_any}, 64'h0);
        tick();
        rst = 1'b0;
        tick();

        // Test 2: x0 never written, never busy
        wen = 1'b1; waddr = 5'd0; wdata = 64'hFFFF;
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        idle();
        raddr1 = 5'd0;
        #1;
        chk("t2_rdata1", rdata1, 64'h0);
        chk("t2_busy1", {63'h0, busy1}, 64'h0);
        chk("t2_busy_any", {63'h0, busy_any}, 64'h0);

        // Test 3: read enable gating, both ports on same register
        wen = 1'b1; waddr = 5'd3; wdata = 64'h1234;
        tick();
        idle();
        ren_rs1 = 1'b1; ren_rs2 = 1'b0;
        raddr1 = 5'd3; raddr2 = 5'd3;
        #1;
        chk("t3_rdata1", rdata1, 64'h1234);
        chk("t3_rdata2", rdata2, 64'h0);
        chk("t3_busy2", {63'h0, busy2}, 64'h0);
        ren_rs2 = 1'b1;
        #1;
        chk("t3_rdata2_en", rdata2, 64'h1234);

        // Test 4: issue then writeback 3 cycles later
        wen = 1'b1; waddr = 5'd7; wdata = 64'h77;
        tick();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        idle();
        raddr1 = 5'd7; ren_rs1 = 1'b1;
        #1;
        chk("t4_busy1", {63'h0, busy1}, 64'h1);
        chk("t4_busy_any", {63'h0, busy_any}, 64'h1);
        tick();
        tick();
        chk("t4_wait_busy1", {63'h0, busy1}, 64'h1);
        wen = 1'b1; waddr = 5'd7; wdata = 64'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("t4_wb_rdata1", rdata1, 64'h55);
        chk("t4_wb_busy1", {63'h0, busy1}, 64'h0);
`else
        chk("t4_wb_rdata1", rdata1, 64'h77);
        chk("t4_wb_busy1", {63'h0, busy1}, 64'h1);
`endif
        tick();
        idle();
        #1;
        chk("t4_after_rdata1", rdata1, 64'h55);
        chk("t4_after_busy1", {63'h0, busy1}, 64'h0);
        chk("t4_after_busy_any", {63'h0, busy_any}, 64'h0);

        // Test 5: issue and writeback to the same busy rd in one cycle
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b1; iss_rd = 5'd9;
        wen = 1'b1; waddr = 5'd9; wdata = 64'h99;
        tick();
        idle();
        raddr2 = 5'd9; ren_rs2 = 1'b1;
        #1;
        chk("t5_busy2", {63'h0, busy2}, 64'h1);
        chk("t5_rdata2", rdata2, 64'h99);
        wen = 1'b1; waddr = 5'd9; wdata = 64'h9A;
        tick();
        idle();
        #1;
        chk("t5_clr_busy2", {63'h0, busy2}, 64'h0);
        chk("t5_clr_rdata2", rdata2, 64'h9A);

        // Test 6: random stream against model, starting from a clean reset
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_busy = '0;
        tick();
        for (int c = 0; c < 300; c++) begin
            wen       = 1'($urandom_range(0, 1));
            waddr     = 5'($urandom_range(0, 7));
            wdata     = {$urandom, $urandom};
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = 5'($urandom_range(0, 7));
            ren_rs1   = ($urandom_range(0, 3) != 0);
            raddr1    = 5'($urandom_range(0, 7));
            ren_rs2   = ($urandom_range(0, 3) != 0);
            raddr2    = (c % 4 == 0) ? waddr : 5'($urandom_range(0, 7));
            #1;
            chk("t6_rdata1", rdata1, exp_rd(ren_rs1, raddr1));
            chk("t6_rdata2", rdata2, exp_rd(ren_rs2, raddr2));
            chk("t6_busy1", {63'h0, busy1}, {63'h0, exp_busy(ren_rs1, raddr1)});
            chk("t6_busy2", {63'h0, busy2}, {63'h0, exp_busy(ren_rs2, raddr2)});
            chk("t6_busy_any", {63'h0, busy_any}, {63'h0, (m_busy != 0)});
            if (wen && waddr != 0) m_rf[waddr] = wdata;
            if (wen && waddr != 0) m_busy[waddr] = 1'b0;
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            tick();
        end
        idle();
        ren_rs1 = 1'b1;
        raddr1 = 5'd0;
        #1;
        chk("t6_x0_final", rdata1, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
